// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller and datapath:
// state encodings, default operand width and small state helpers.
package mult_pkg;

  // Default operand width; controller and datapath must agree on it.
  localparam int DEFAULT_WIDTH = 4;

  // Raw 3-bit state encodings, visible to any block that needs to decode state.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_ADD   = ST_ADD,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  // True while an operation is in progress (LOAD through DONE).
  function automatic logic in_op(state_e s);
    return (s != S_IDLE);
  endfunction

  // Counter width for a given operand width (never below one bit).
  function automatic int count_width(int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/multiplier_controller_taint1bit_if.sv
// Strobe interface between the multiplier controller (master) and the
// shift-add datapath (slave). Each strobe carries a one-bit taint shadow.
interface multiplier_controller_taint1bit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Datapath -> controller
  logic [WIDTH-1:0] multiplierReg;
  logic             multiplierReg_t;

  // Controller -> datapath strobes and their taints
  logic mrld;
  logic mrld_t;
  logic mdld;
  logic mdld_t;
  logic rsclear;
  logic rsclear_t;
  logic rsload;
  logic rsload_t;
  logic rsshr;
  logic rsshr_t;

  modport master (
    input  multiplierReg, multiplierReg_t,
    output mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t,
           rsload, rsload_t, rsshr, rsshr_t
  );

  modport slave (
    output multiplierReg, multiplierReg_t,
    input  mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t,
           rsload, rsload_t, rsshr, rsshr_t
  );

endinterface

// File: rtl/multiplier_controller_taint1bit.sv
// Control FSM for the shift-add sequential multiplier with 1-bit taint
// tracking. All outputs are Moore-decoded from the state register, except
// that rsload follows the multiplier bit selected by the counter in ADD.
module multiplier_controller_taint1bit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic start_t,
  multiplier_controller_taint1bit_if.master dp,
  output logic busy,
  output logic busy_t,
  output logic done,
  output logic done_t
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e        state_reg;
  state_e        state_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          taint_reg;
  logic          taint_next;

  // Control-flow taint that applies to every output while an op is running.
  logic          op_taint;

  // State, bit counter and control-flow taint registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      taint_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      taint_reg <= taint_next;
    end
  end

  // Next-state logic and strobe decode.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    taint_next = taint_reg;
    dp.mrld    = 1'b0;
    dp.mdld    = 1'b0;
    dp.rsclear = 1'b0;
    dp.rsload  = 1'b0;
    dp.rsshr   = 1'b0;
    busy       = in_op(state_reg);
    done       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // The branch out of IDLE depends on start, so its taint is the
        // taint of the whole upcoming sequence.
        taint_next = start_t;
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        dp.mrld    = 1'b1;
        dp.mdld    = 1'b1;
        dp.rsclear = 1'b1;
        count_next = '0;
        state_next = S_ADD;
      end
      S_ADD: begin
        dp.rsload  = dp.multiplierReg[count_reg];
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        dp.rsshr = 1'b1;
        if (count_reg == LAST) begin
          state_next = S_DONE;
        end else begin
          count_next = count_reg + 1'b1;
          state_next = S_ADD;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        count_next = '0;
        taint_next = 1'b0;
      end
    endcase
  end

  // Taint decode: idle strobes are constants, so their taint is zero; during
  // an op every output inherits the control-flow taint, and rsload in ADD
  // additionally depends on the multiplier register contents.
  always_comb begin
    op_taint     = in_op(state_reg) ? taint_reg : 1'b0;
    busy_t       = op_taint;
    done_t       = op_taint;
    dp.mrld_t    = op_taint;
    dp.mdld_t    = op_taint;
    dp.rsclear_t = op_taint;
    dp.rsshr_t   = op_taint;
    dp.rsload_t  = op_taint;
    if (state_reg == S_ADD) begin
      dp.rsload_t = op_taint | dp.multiplierReg_t;
    end
  end

endmodule

// File: tb/tb_multiplier_controller_taint1bit.sv
// Self-checking bench for multiplier_controller_taint1bit with a behavioural
// shift-add datapath and a cycle-offset timeline model of the controller.
module tb_multiplier_controller_taint1bit;
  import mult_pkg::*;

  localparam int W    = 4;
  localparam int LAST = 2 * W + 2;  // op cycle holding DONE

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_t = 1'b0;
  logic busy, busy_t, done, done_t;

  int checks = 0;
  int errors = 0;

  // Operands presented to the datapath model
  logic [W-1:0] mr_in = '0;
  logic [W-1:0] md_in = '0;
  logic         mr_t_in = 1'b0;

  multiplier_controller_taint1bit_if #(.WIDTH(W)) dp_if ();

  multiplier_controller_taint1bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .start_t (start_t),
    .dp      (dp_if),
    .busy    (busy),
    .busy_t  (busy_t),
    .done    (done),
    .done_t  (done_t)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: shift-right sum, multiplicand added into the top half
  logic [W-1:0]   mr_q = '0;
  logic [W-1:0]   md_q = '0;
  logic [2*W:0]   rs   = '0;
  assign dp_if.multiplierReg   = mr_q;
  assign dp_if.multiplierReg_t = mr_t_in;

  always @(posedge clk) begin
    if (dp_if.mrld) mr_q <= mr_in;
    if (dp_if.mdld) md_q <= md_in;
    if (dp_if.rsclear)     rs <= '0;
    else if (dp_if.rsload) rs <= rs + {1'b0, md_q, {W{1'b0}}};
    else if (dp_if.rsshr)  rs <= rs >> 1;
  end

  // Controller model: op = cycles since the sampled start (0 = idle)
  int   op = 0;
  logic op_taint = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= 0;
      op_taint <= 1'b0;
    end else if (op == 0) begin
      if (start) begin
        op       <= 1;
        op_taint <= start_t;
      end
    end else if (op == LAST) begin
      op <= 0;
    end else begin
      op <= op + 1;
    end
  end

  // Expected output vector, bit 0 = rsshr_t ... bit 13 = busy
  function automatic logic [13:0] expected(int o, logic tnt, logic [W-1:0] mr, logic mrt);
    logic bz, ld, ad, sh, dn, rl, t;
    bz = (o != 0);
    ld = (o == 1);
    ad = (o >= 2) && (o <= 2 * W) && (o % 2 == 0);
    sh = (o >= 3) && (o <= 2 * W + 1) && (o % 2 == 1);
    dn = (o == LAST);
    rl = 1'b0;
    if (ad) rl = mr[(o - 2) / 2];
    t  = bz ? tnt : 1'b0;
    return {bz, t, dn, t, ld, t, ld, t, ld, t, rl, t | (ad & mrt), sh, t};
  endfunction

  logic [13:0] exp_vec;
  logic [13:0] act_vec;
  assign exp_vec = expected(op, op_taint, mr_in, mr_t_in);
  assign act_vec = {busy, busy_t, done, done_t,
                    dp_if.mrld, dp_if.mrld_t, dp_if.mdld, dp_if.mdld_t,
                    dp_if.rsclear, dp_if.rsclear_t, dp_if.rsload, dp_if.rsload_t,
                    dp_if.rsshr, dp_if.rsshr_t};

  string names [14] = '{"rsshr_t", "rsshr", "rsload_t", "rsload", "rsclear_t", "rsclear",
                        "mdld_t", "mdld", "mrld_t", "mrld", "done_t", "done",
                        "busy_t", "busy"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int i = 0; i < 14; i++) begin
      check(names[i], 32'(act_vec[i]), 32'(exp_vec[i]));
    end
  end

  // Run one operation with a single-cycle start pulse; returns observations
  // collected from LOAD (n=1) up to the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic at, input logic st, output int n,
                        output logic [7:0] prod, output logic [W-1:0] rsm,
                        output logic [W-1:0] rstm, output logic oth_or,
                        output logic all_and);
    mr_in   = a;
    md_in   = b;
    mr_t_in = at;
    @(posedge clk); #1;
    start   = 1'b1;
    start_t = st;
    @(posedge clk); #1;
    start   = 1'b0;
    start_t = 1'b0;
    n = 0; rsm = '0; rstm = '0; oth_or = 1'b0; all_and = 1'b1;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if ((n % 2 == 0) && (n >= 2) && (n <= 2 * W)) begin
        rsm[(n - 2) / 2]  = dp_if.rsload;
        rstm[(n - 2) / 2] = dp_if.rsload_t;
      end
      oth_or  = oth_or | dp_if.mrld_t | dp_if.mdld_t | dp_if.rsclear_t |
                dp_if.rsshr_t | busy_t | done_t;
      all_and = all_and & dp_if.mrld_t & dp_if.mdld_t & dp_if.rsclear_t &
                dp_if.rsshr_t & dp_if.rsload_t & busy_t & done_t;
      if (done) break;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    prod = rs[7:0];
    $display("op %s: %0d x %0d -> product %0d, done at cycle %0d", tag, a, b, prod, n);
  endtask

  initial begin
    int n;
    int dones;
    logic [7:0]   prod;
    logic [W-1:0] rsm, rstm;
    logic         oth_or, all_and;

    // Reset state
    #2;
    check("reset_outputs", 32'(act_vec), 32'd0);
    #21 rst_n = 1'b1;

    // 1: 11 x 13
    run_op("t1", 4'd11, 4'd13, 1'b0, 1'b0, n, prod, rsm, rstm, oth_or, all_and);
    check("t1_latency", n, 10);
    check("t1_product", 32'(prod), 32'd143);
    check("t1_rsload_pattern", 32'(rsm), 32'b1011);
    check("t1_taint_any", 32'(oth_or | (|rstm)), 32'd0);

    // 2: zero multiplier
    run_op("t2", 4'd0, 4'd15, 1'b0, 1'b0, n, prod, rsm, rstm, oth_or, all_and);
    check("t2_latency", n, 10);
    check("t2_product", 32'(prod), 32'd0);
    check("t2_rsload_pattern", 32'(rsm), 32'd0);

    // 3: tainted start
    run_op("t3", 4'd5, 4'd7, 1'b0, 1'b1, n, prod, rsm, rstm, oth_or, all_and);
    check("t3_all_taint_high", 32'(all_and), 32'd1);
    check("t3_product", 32'(prod), 32'd35);
    @(negedge clk);
    check("t3_idle_taint_clear", 32'(oth_or & 1'b0) | 32'(busy_t | done_t | dp_if.mrld_t |
          dp_if.mdld_t | dp_if.rsclear_t | dp_if.rsload_t | dp_if.rsshr_t), 32'd0);

    // 4: tainted multiplier register
    run_op("t4", 4'b0101, 4'd3, 1'b1, 1'b0, n, prod, rsm, rstm, oth_or, all_and);
    mr_t_in = 1'b0;
    check("t4_rsload_t_mask", 32'(rstm), 32'b1111);
    check("t4_rsload_pattern", 32'(rsm), 32'b0101);
    check("t4_other_taint", 32'(oth_or), 32'd0);
    check("t4_product", 32'(prod), 32'd15);

    // 5: start held high through two ops
    mr_in = 4'd3; md_in = 4'd5;
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    check("t5_first_done", 32'(done), 32'd1);
    n = 0; dones = 0;
    do begin
      @(negedge clk);
      n++;
      if (done) dones++;
    end while (!dp_if.mrld && n < 30);
    check("t5_gap_to_load", n, 2);
    check("t5_no_extra_done", dones, 0);
    n = 1;
    while (!done && n < 30) begin @(negedge clk); n++; end
    check("t5_second_latency", n, 10);
    check("t5_product", 32'(rs[7:0]), 32'd15);
    start = 1'b0;
    dones = 0;
    repeat (14) begin @(negedge clk); if (done) dones++; end
    check("t5_not_queued", dones, 0);
    $display("op t5: back-to-back ops with start held high");

    // 6: reset in the 2nd SHIFT cycle
    mr_in = 4'd6; md_in = 4'd9;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 5) begin @(negedge clk); n++; end
    check("t6_in_second_shift", 32'(dp_if.rsshr), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset_outputs", 32'(act_vec), 32'd0);
    @(posedge clk); #1;
    check("t6_held_in_reset", 32'(act_vec), 32'd0);
    #1 rst_n = 1'b1;
    $display("op t6: reset asserted mid-operation");
    run_op("t6", 4'd7, 4'd9, 1'b0, 1'b0, n, prod, rsm, rstm, oth_or, all_and);
    check("t6_latency", n, 10);
    check("t6_product", 32'(prod), 32'd63);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
